// File: rtl/time_disp_scan.sv
// time_disp_scan
// Display-side consumer of the 24-hour clock. It takes coherent BCD snapshots
// of HH:MM:SS and scans them onto a 6-digit, common-anode, multiplexed
// 7-segment display, one digit per slot of SCAN_DIV cycles.
//
// Ports:
//   kh_clk      system clock, rising edge
//   reset       synchronous, active-high reset
//   time_bcd    {Ht,Hu,Mt,Mu,St,Su}, 4-bit BCD each, Ht in [23:20]
//   time_valid  single-cycle strobe qualifying time_bcd
//   blank_lz    blank the hour-tens digit when it is 0
//   seg_n       active-low segments {g,f,e,d,c,b,a}
//   dp_n        active-low decimal point, used as the colon
//   an_n        active-low anodes, an_n[5]=Ht ... an_n[0]=Su
//   bcd_err     high while the displayed frame holds a digit > 9
module time_disp_scan #(
    parameter int SCAN_DIV = 4,
    parameter int BLANK    = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [23:0] time_bcd,
    input  logic        time_valid,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n,
    output logic        bcd_err
);

    localparam int          SW         = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK);

    // Scan position
    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    idx_q, idx_d;

    // Snapshot buffering
    logic [23:0]   disp_q, disp_d;
    logic [23:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          phase_q, phase_d;

    // Registered pins
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [5:0]    an_q, an_d;
    logic          err_q, err_d;

    logic          frame_end;
    logic          load;
    logic [23:0]   load_val;
    logic [3:0]    cur_digit;
    logic          lz_hit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // dash: non-BCD digit
        endcase
        return s;
    endfunction

    // Slot counter and digit index
    always_comb begin
        frame_end = (slot_q == SLOT_LAST) && (idx_q == 3'd5);
        slot_d    = slot_q + 1'b1;
        idx_d     = idx_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Snapshot: strobes land in the pending register; the display register
    // only changes on the frame boundary so a frame is never torn. A strobe
    // on the boundary cycle itself bypasses the pending register.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        phase_d    = phase_q;
        load       = 1'b0;
        load_val   = disp_q;
        if (frame_end) begin
            if (time_valid) begin
                load     = 1'b1;
                load_val = time_bcd;
            end else if (pend_vld_q) begin
                load     = 1'b1;
                load_val = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (time_valid) begin
            pend_d     = time_bcd;
            pend_vld_d = 1'b1;
        end
        if (load) begin
            disp_d = load_val;
            // Colon blinks in step with the seconds digit changing.
            if (load_val[3:0] != disp_q[3:0])
                phase_d = ~phase_q;
        end
    end

    // Digit currently being scanned, idx 0 = Ht
    always_comb begin
        case (idx_q)
            3'd0:    cur_digit = disp_q[23:20];
            3'd1:    cur_digit = disp_q[19:16];
            3'd2:    cur_digit = disp_q[15:12];
            3'd3:    cur_digit = disp_q[11:8];
            3'd4:    cur_digit = disp_q[7:4];
            default: cur_digit = disp_q[3:0];
        endcase
    end

    // Output stage. Computed from the current scan position, so the pins lag
    // it by one cycle; disp_q and the position change on the same edge at a
    // frame boundary, which keeps digit content and anode aligned.
    always_comb begin
        an_d   = 6'h3F;
        seg_d  = 7'h7F;
        dp_d   = 1'b1;
        lz_hit = (idx_q == 3'd0) && blank_lz && (disp_q[23:20] == 4'd0);
        if ((slot_q >= BLANK_END) && !lz_hit) begin
            an_d  = 6'h3F ^ (6'd1 << (3'd5 - idx_q));
            seg_d = seg_decode(cur_digit);
            dp_d  = ~(phase_q && ((idx_q == 3'd1) || (idx_q == 3'd3)));
        end
    end

    // Error flag follows the display register by one cycle.
    always_comb begin
        err_d = (disp_q[23:20] > 4'd9) || (disp_q[19:16] > 4'd9) ||
                (disp_q[15:12] > 4'd9) || (disp_q[11:8]  > 4'd9) ||
                (disp_q[7:4]   > 4'd9) || (disp_q[3:0]   > 4'd9);
    end

    always_ff @(posedge kh_clk) begin
        if (reset) begin
            slot_q     <= '0;
            idx_q      <= 3'd0;
            disp_q     <= 24'h0;
            pend_q     <= 24'h0;
            pend_vld_q <= 1'b0;
            phase_q    <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= 6'h3F;
            err_q      <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            err_q      <= err_d;
        end
    end

    assign seg_n   = seg_q;
    assign dp_n    = dp_q;
    assign an_n    = an_q;
    assign bcd_err = err_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Bench for time_disp_scan with SCAN_DIV=4, BLANK=1 (24-cycle frames).
// Each table row describes one frame: the value shown, expected segment
// patterns per digit, and up to two strobes driven during that frame.
module tb_time_disp_scan;

    logic        kh_clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] time_bcd = 24'h0;
    logic        time_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [5:0]  an_n;
    logic        bcd_err;

    time_disp_scan #(.SCAN_DIV(4), .BLANK(1)) dut (
        .kh_clk(kh_clk), .reset(reset), .time_bcd(time_bcd),
        .time_valid(time_valid), .blank_lz(blank_lz), .seg_n(seg_n),
        .dp_n(dp_n), .an_n(an_n), .bcd_err(bcd_err)
    );

    always #5 kh_clk = ~kh_clk;

    typedef struct {
        logic [23:0] shown;
        logic        blz;
        logic        lzb;
        logic [41:0] segs;   // {Ht,Hu,Mt,Mu,St,Su} seg_n values
        logic        err;
        int          nstr;
        int          off0;
        logic [23:0] v0;
        int          off1;
        logic [23:0] v1;
    } vec_t;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   errors = 0;
    int   checks = 0;
    logic exp_phase = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called when aligned on slot 0 / digit 0 of a frame.
    task automatic run_frame(input vec_t v, input string tag);
        exp_t        e;
        logic [23:0] loaded;
        int          slot, idx;
        blank_lz = v.blz;
        for (int j = 0; j < 24; j++) begin
            slot  = j % 4;
            idx   = j / 4;
            e.an  = 6'h3F;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.err = v.err;
            if (slot >= 1 && !(idx == 0 && v.lzb)) begin
                e.an  = 6'h3F ^ (6'd1 << (5 - idx));
                e.seg = v.segs[(5 - idx) * 7 +: 7];
                e.dp  = !(exp_phase && (idx == 1 || idx == 3));
            end
            sb.push_back(e);
        end
        for (int j = 0; j < 24; j++) begin
            time_valid = ((v.nstr >= 1) && (j == v.off0)) || ((v.nstr == 2) && (j == v.off1));
            time_bcd   = ((v.nstr == 2) && (j == v.off1)) ? v.v1 : v.v0;
            @(posedge kh_clk);
            #1;
            time_valid = 1'b0;
            e = sb.pop_front();
            chk($sformatf("%s_c%0d_an", tag, j), 32'(an_n), 32'(e.an));
            chk($sformatf("%s_c%0d_seg", tag, j), 32'(seg_n), 32'(e.seg));
            chk($sformatf("%s_c%0d_dp", tag, j), 32'(dp_n), 32'(e.dp));
            chk($sformatf("%s_c%0d_err", tag, j), 32'(bcd_err), 32'(e.err));
        end
        if (v.nstr > 0) begin
            loaded = (v.nstr == 2) ? v.v1 : v.v0;
            if (loaded[3:0] != v.shown[3:0])
                exp_phase = ~exp_phase;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, 32'(an_n), 32'h3F);
        chk({tag, "_seg"}, 32'(seg_n), 32'h7F);
        chk({tag, "_dp"}, 32'(dp_n), 32'h1);
        chk({tag, "_err"}, 32'(bcd_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = '{24'h000000, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 0, 1, 7, 24'h123456, 0, 24'h0};
        vecs[1]  = '{24'h123456, 0, 0, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}, 0, 2, 3, 24'h111111, 10, 24'h222222};
        vecs[2]  = '{24'h222222, 0, 0, {7'h24,7'h24,7'h24,7'h24,7'h24,7'h24}, 0, 1, 23, 24'h090000, 0, 24'h0};
        vecs[3]  = '{24'h090000, 0, 0, {7'h40,7'h10,7'h40,7'h40,7'h40,7'h40}, 0, 1, 5, 24'h012345, 0, 24'h0};
        vecs[4]  = '{24'h012345, 1, 1, {7'h7F,7'h79,7'h24,7'h30,7'h19,7'h12}, 0, 0, 0, 24'h0, 0, 24'h0};
        vecs[5]  = '{24'h012345, 0, 0, {7'h40,7'h79,7'h24,7'h30,7'h19,7'h12}, 0, 1, 2, 24'h000001, 0, 24'h0};
        vecs[6]  = '{24'h000001, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h79}, 0, 1, 9, 24'h000002, 0, 24'h0};
        vecs[7]  = '{24'h000002, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h24}, 0, 1, 14, 24'h000002, 0, 24'h0};
        vecs[8]  = '{24'h000002, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h24}, 0, 1, 20, 24'h000003, 0, 24'h0};
        vecs[9]  = '{24'h000003, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h30}, 0, 1, 1, 24'hA00000, 0, 24'h0};
        vecs[10] = '{24'hA00000, 1, 0, {7'h3F,7'h40,7'h40,7'h40,7'h40,7'h40}, 1, 1, 16, 24'h000000, 0, 24'h0};
        vecs[11] = '{24'h000000, 0, 0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 0, 0, 0, 24'h0, 0, 24'h0};

        // Reset and release; afterwards the scan sits at slot 0 / digit 0.
        reset = 1'b1;
        repeat (3) @(posedge kh_clk);
        #1;
        chk_reset_vals("reset");
        reset     = 1'b0;
        exp_phase = 1'b0;

        for (int i = 0; i < 12; i++)
            run_frame(vecs[i], $sformatf("v%0d", i));

        // Reset mid-slot, with a pending strobe outstanding and a strobe
        // coincident with reset: neither may survive.
        for (int j = 0; j < 6; j++) begin
            time_valid = (j == 2);
            time_bcd   = 24'h123456;
            @(posedge kh_clk);
            #1;
            time_valid = 1'b0;
        end
        reset      = 1'b1;
        time_valid = 1'b1;
        time_bcd   = 24'h777777;
        @(posedge kh_clk);
        #1;
        chk_reset_vals("midreset");
        reset      = 1'b0;
        time_valid = 1'b0;
        exp_phase  = 1'b0;
        v = vecs[11];
        run_frame(v, "post0");
        run_frame(v, "post1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
